// File: rtl/video_led_frame_ctl_if.sv
// Command port between host requesters and the LED frame controller.
interface video_led_frame_ctl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_idx;

    modport master (output cmd_valid, output cmd_op, output cmd_idx, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_idx, output cmd_ready);
endinterface

// File: rtl/video_led_frame_ctl.sv
// Frame-synchronous LED vector controller: queued per-LED commands, tear-free commit
// on the end-of-active pulse, and a frame-counted blink scheduler.
module video_led_frame_ctl #(
    parameter int unsigned C_FIFO_DEPTH   = 4,
    parameter int unsigned C_BLINK_FRAMES = 30,
    parameter int unsigned C_LED_N        = 18
) (
    input  logic                 CK_i,
    input  logic                 XARST_i,
    input  logic                 CK_EE_i,
    input  logic                 RST_i,
    input  logic                 FRAME_i,
    video_led_frame_ctl_if.slave cmd,
    output logic [C_LED_N-1:0]   LEDs_ON_o,
    output logic                 BLINK_PH_o,
    output logic [4:0]           FIFO_LVLs_o,
    output logic                 ERR_o,
    output logic                 COMMIT_o
);
    localparam int unsigned AW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned LW = 5;
    localparam int unsigned IW = 5;
    localparam int unsigned FW = 8;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COMMIT} state_t;
    typedef struct packed {
        logic [1:0]    op;
        logic [IW-1:0] idx;
    } cmd_t;

    state_t             state, state_nxt;
    cmd_t               mem [C_FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [C_LED_N-1:0] work, blen;
    logic [FW-1:0]      fctr;
    logic               frame_pend;

    logic               ready_c, push_c, pop_c, frame_c, commit_c;
    logic               idx_ok_c, wrap_c, ph_nxt_c;
    logic [LW-1:0]      lvl_nxt_c;
    cmd_t               head_c;
    logic [C_LED_N-1:0] mask_c, leds_nxt_c;

    // FIFO handshake; ready is a direct decode of the registered level
    assign ready_c       = (FIFO_LVLs_o != LW'(C_FIFO_DEPTH));
    assign cmd.cmd_ready = ready_c;
    assign push_c        = CK_EE_i & cmd.cmd_valid & ready_c;
    assign pop_c         = CK_EE_i & (state == S_APPLY) & (FIFO_LVLs_o != '0);
    assign lvl_nxt_c     = FIFO_LVLs_o + LW'(push_c) - LW'(pop_c);
    assign frame_c       = CK_EE_i & (FRAME_i | frame_pend);

    // Head-of-queue decode; an out-of-range index yields an empty mask
    assign head_c   = mem[rd_ptr];
    assign idx_ok_c = (32'(head_c.idx) < C_LED_N);
    assign mask_c   = idx_ok_c ? ({{(C_LED_N-1){1'b0}}, 1'b1} << head_c.idx) : '0;

    // Blink phase used by the commit is the post-update phase
    assign wrap_c     = (fctr == FW'(C_BLINK_FRAMES - 1));
    assign ph_nxt_c   = BLINK_PH_o ^ wrap_c;
    assign leds_nxt_c = work & ~(blen & {C_LED_N{ph_nxt_c}});

    always_comb begin
        state_nxt = state;
        commit_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_c)                  state_nxt = S_COMMIT;
                else if (FIFO_LVLs_o != '0)   state_nxt = S_APPLY;
            end
            S_APPLY: begin
                if (frame_c)                  state_nxt = S_COMMIT;
                else if (lvl_nxt_c != '0)     state_nxt = S_APPLY;
                else                          state_nxt = S_IDLE;
            end
            S_COMMIT: begin
                commit_c  = CK_EE_i;
                state_nxt = (lvl_nxt_c != '0) ? S_APPLY : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state <= S_IDLE;
        end else if (CK_EE_i) begin
            state <= RST_i ? S_IDLE : state_nxt;
        end
    end

    // Queue storage needs no reset: pointers and level define validity
    always_ff @(posedge CK_i) begin
        if (push_c) mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_idx};
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            FIFO_LVLs_o <= '0;
            work        <= '0;
            blen        <= '0;
            fctr        <= '0;
            frame_pend  <= 1'b0;
            LEDs_ON_o   <= '0;
            BLINK_PH_o  <= 1'b0;
            ERR_o       <= 1'b0;
            COMMIT_o    <= 1'b0;
        end else if (CK_EE_i) begin
            if (RST_i) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                FIFO_LVLs_o <= '0;
                work        <= '0;
                blen        <= '0;
                fctr        <= '0;
                frame_pend  <= 1'b0;
                LEDs_ON_o   <= '0;
                BLINK_PH_o  <= 1'b0;
                ERR_o       <= 1'b0;
                COMMIT_o    <= 1'b0;
            end else begin
                FIFO_LVLs_o <= lvl_nxt_c;
                COMMIT_o    <= commit_c;
                // A frame landing during a commit is held for one cycle
                frame_pend  <= (state == S_COMMIT) & FRAME_i;
                if (push_c) wr_ptr <= wr_ptr + AW'(1);
                if (pop_c) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    if (!idx_ok_c) ERR_o <= 1'b1;
                    case (head_c.op)
                        2'd0:    work <= work & ~mask_c;
                        2'd1:    work <= work | mask_c;
                        2'd2:    work <= work ^ mask_c;
                        default: blen <= blen ^ mask_c;
                    endcase
                end
                if (commit_c) begin
                    LEDs_ON_o  <= leds_nxt_c;
                    BLINK_PH_o <= ph_nxt_c;
                    fctr       <= wrap_c ? '0 : fctr + FW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_video_led_frame_ctl.sv
// Scoreboard bench for video_led_frame_ctl: a frame-level model predicts every commit,
// a negedge monitor compares each COMMIT_o against the queued expectation.
`timescale 1ns/1ps
module tb_video_led_frame_ctl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BLINK = 2;
    localparam int unsigned NLED  = 18;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            ck_ee = 1'b0;
    logic            srst  = 1'b0;
    logic            frame = 1'b0;
    logic [NLED-1:0] leds;
    logic            ph;
    logic [4:0]      lvl;
    logic            err;
    logic            commit;

    video_led_frame_ctl_if cmd_if();

    video_led_frame_ctl #(
        .C_FIFO_DEPTH(DEPTH), .C_BLINK_FRAMES(BLINK), .C_LED_N(NLED)
    ) dut (
        .CK_i(clk), .XARST_i(rst_n), .CK_EE_i(ck_ee), .RST_i(srst), .FRAME_i(frame),
        .cmd(cmd_if), .LEDs_ON_o(leds), .BLINK_PH_o(ph), .FIFO_LVLs_o(lvl),
        .ERR_o(err), .COMMIT_o(commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NLED-1:0] leds;
        logic            ph;
        bit              ph_chk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_commits = 0;
    int   max_lvl   = 0;
    bit   saw_stall = 0;
    bit   bad_ready = 0;
    bit   loose     = 0;

    // Frame-level reference state
    logic [NLED-1:0] m_work, m_blen;
    logic            m_ph;
    int unsigned     m_fctr;
    logic            m_err;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    task automatic model_reset();
        m_work = '0; m_blen = '0; m_ph = 1'b0; m_fctr = 0; m_err = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [4:0] idx);
        if (32'(idx) >= NLED) begin
            m_err = 1'b1;
        end else begin
            case (op)
                2'd0:    m_work[idx] = 1'b0;
                2'd1:    m_work[idx] = 1'b1;
                2'd2:    m_work[idx] = ~m_work[idx];
                default: m_blen[idx] = ~m_blen[idx];
            endcase
        end
    endtask

    task automatic model_frame(input bit ph_chk);
        exp_t e;
        if (m_fctr == BLINK - 1) begin m_fctr = 0; m_ph = ~m_ph; end
        else m_fctr++;
        e.leds   = m_ph ? (m_work & ~m_blen) : m_work;
        e.ph     = m_ph;
        e.ph_chk = ph_chk;
        sb_q.push_back(e);
    endtask

    // Monitor: every commit is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
            if (cmd_if.cmd_valid && !cmd_if.cmd_ready) saw_stall = 1;
            if (lvl == 5'(DEPTH) && cmd_if.cmd_ready) bad_ready = 1;
            if (commit) begin
                n_commits++;
                if (!loose) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_commit", 32'(commit), 32'(0));
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("commit_leds", 32'(leds), 32'(mon_e.leds));
                        if (mon_e.ph_chk) chk("commit_ph", 32'(ph), 32'(mon_e.ph));
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [4:0] idx);
        bit done = 0;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op; cmd_if.cmd_idx = idx;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = cmd_if.cmd_ready && ck_ee;
            @(posedge clk); #1;
        end
        cmd_if.cmd_valid = 1'b0;
        if (done) model_apply(op, idx);
        else chk("push_timeout", 32'(cmd_if.cmd_ready), 32'(1));
    endtask

    task automatic wait_drain();
        int i = 0;
        while (lvl != 5'd0 && i < 200) begin step(1); i++; end
        if (lvl != 5'd0) chk("drain_timeout", 32'(lvl), 32'(0));
        step(3);
    endtask

    task automatic frame_pulse(input bit ph_chk);
        bit seen = 0;
        frame = 1'b1;
        model_frame(ph_chk);
        step(1);
        frame = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = commit; end
        if (!seen) chk("commit_timeout", 32'(commit), 32'(1));
        else begin @(negedge clk); chk("commit_one_cycle", 32'(commit), 32'(0)); end
        step(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_leds"},  32'(leds), 32'(0));
        chk({tag, "_ph"},    32'(ph), 32'(0));
        chk({tag, "_err"},   32'(err), 32'(0));
        chk({tag, "_level"}, 32'(lvl), 32'(0));
        chk({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'(1));
        chk({tag, "_commit"}, 32'(commit), 32'(0));
    endtask

    initial begin
        int blink_exp [6] = '{1, 0, 0, 1, 1, 0};
        int c0;
        logic [4:0] ridx;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'd0; cmd_if.cmd_idx = 5'd0;
        model_reset();
        step(2);
        check_reset_outputs("por");
        rst_n = 1'b1; ck_ee = 1'b1;
        step(2);

        // Basic commit: nothing visible until the frame pulse
        push_cmd(2'd1, 5'd0);
        push_cmd(2'd1, 5'd17);
        wait_drain();
        chk("leds_before_frame", 32'(leds), 32'(0));
        frame_pulse(1);
        chk("basic_leds", 32'(leds), 32'h20001);

        // Frame coincides with the pop of A; B pushed in that cycle waits a frame
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'd1; cmd_if.cmd_idx = 5'd9;
        step(1);
        model_apply(2'd1, 5'd9);
        cmd_if.cmd_valid = 1'b0;
        step(1);
        frame = 1'b1; model_frame(1);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_idx = 5'd11;
        step(1);
        frame = 1'b0; cmd_if.cmd_valid = 1'b0;
        model_apply(2'd1, 5'd11);
        step(4);
        chk("simul_leds", 32'(leds), 32'h20201);
        wait_drain();
        frame_pulse(1);
        chk("simul_next_leds", 32'(leds), 32'h20A01);

        // Backpressure with FRAME_i held high
        srst = 1'b1; step(1); srst = 1'b0; model_reset();
        chk("srst_leds", 32'(leds), 32'(0));
        chk("srst_ph", 32'(ph), 32'(0));
        loose = 1; max_lvl = 0; saw_stall = 0; bad_ready = 0;
        frame = 1'b1;
        push_cmd(2'd0, 5'd6); push_cmd(2'd0, 5'd7); push_cmd(2'd0, 5'd8);
        push_cmd(2'd1, 5'd3); push_cmd(2'd2, 5'd3); push_cmd(2'd1, 5'd4);
        push_cmd(2'd0, 5'd4); push_cmd(2'd2, 5'd5);
        frame = 1'b0;
        wait_drain();
        step(3);
        loose = 0;
        chk("bp_max_level", 32'(max_lvl), 32'(DEPTH));
        chk("bp_stalled", 32'(saw_stall), 32'(1));
        chk("bp_ready_when_full", 32'(bad_ready), 32'(0));
        frame_pulse(0);
        chk("bp_leds", 32'(leds), 32'h00020);

        // Blink scheduler
        srst = 1'b1; step(1); srst = 1'b0; model_reset();
        push_cmd(2'd1, 5'd2);
        push_cmd(2'd3, 5'd2);
        push_cmd(2'd1, 5'd5);
        wait_drain();
        for (int i = 0; i < 6; i++) begin
            frame_pulse(1);
            chk("blink_bit2", 32'(leds[2]), 32'(blink_exp[i]));
            chk("blink_bit5", 32'(leds[5]), 32'(1));
        end

        // Invalid index sets a sticky error without touching the LED state
        push_cmd(2'd1, 5'd20);
        wait_drain();
        chk("err_set", 32'(err), 32'(1));
        frame_pulse(1);
        push_cmd(2'd1, 5'd1);
        wait_drain();
        chk("err_sticky", 32'(err), 32'(1));
        frame_pulse(1);

        // Frame while clock enable is low must be ignored
        c0 = n_commits;
        ck_ee = 1'b0; frame = 1'b1;
        step(3);
        frame = 1'b0;
        step(1);
        ck_ee = 1'b1;
        step(6);
        chk("gated_no_commit", 32'(n_commits), 32'(c0));
        chk("gated_commit_low", 32'(commit), 32'(0));

        // Randomized command bursts, one frame per burst
        for (int r = 0; r < 24; r++) begin
            int n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) ridx = 5'($urandom_range(18, 31));
                else ridx = 5'($urandom_range(0, 17));
                push_cmd(2'($urandom_range(0, 3)), ridx);
            end
            wait_drain();
            chk("rand_err", 32'(err), 32'(m_err));
            frame_pulse(1);
        end

        // Asynchronous reset with commands in flight discards them
        loose = 1;
        frame = 1'b1;
        push_cmd(2'd1, 5'd1); push_cmd(2'd1, 5'd2); push_cmd(2'd1, 5'd3);
        rst_n = 1'b0; frame = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        step(2);
        rst_n = 1'b1;
        model_reset();
        step(2);
        loose = 0;
        push_cmd(2'd1, 5'd13);
        wait_drain();
        frame_pulse(1);
        chk("post_reset_leds", 32'(leds), 32'h02000);

        step(4);
        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t reached limit 2000000 without finishing", $time);
        $fatal(1, "watchdog");
    end
endmodule
